// File: rtl/regbank_writeback.sv
// Write-side front end for the register bank: ALU and load results, a small FIFO, registered write port.
// Optional REGBANK_WB_ZERO_REG_EN: writes to register 0 are accepted but dropped, never reported pending.
module regbank_writeback #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    AluValid,
    output logic                    AluReady,
    input  logic [ADDR_W-1:0]       AluDir,
    input  logic [DATA_W-1:0]       AluData,
    input  logic                    MemValid,
    output logic                    MemReady,
    input  logic [ADDR_W-1:0]       MemDir,
    input  logic [DATA_W-1:0]       MemData,
    input  logic [ADDR_W-1:0]       QueryA,
    input  logic [ADDR_W-1:0]       QueryB,
    output logic                    PendingA,
    output logic                    PendingB,
    output logic                    WriteFlag,
    output logic [ADDR_W-1:0]       DirW,
    output logic [DATA_W-1:0]       WriteData,
    output logic [$clog2(DEPTH):0]  Count,
    output logic                    Full,
    output logic                    Empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_fifo_dir  [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic              r_write_flag;
    logic [ADDR_W-1:0] r_dir_w;
    logic [DATA_W-1:0] r_write_data;

    logic [CNT_W-1:0]  w_free;
    logic              w_mem_drop;
    logic              w_alu_drop;
    logic              w_mem_slot;
    logic              w_mem_push;
    logic              w_alu_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_push_cnt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [PTR_W-1:0]  w_alu_idx;
    logic [DEPTH-1:0]  w_entry_valid;
    logic              w_pend_a;
    logic              w_pend_b;

`ifdef REGBANK_WB_ZERO_REG_EN
    assign w_mem_drop = (MemDir == '0);
    assign w_alu_drop = (AluDir == '0);
`else
    assign w_mem_drop = 1'b0;
    assign w_alu_drop = 1'b0;
`endif

    // Free slots come from Count alone; the pop happening this cycle is not credited.
    assign w_free     = CNT_W'(DEPTH) - r_count;
    assign w_mem_slot = MemValid && !w_mem_drop;

    assign MemReady = w_mem_drop || (w_free != '0);
    assign AluReady = w_alu_drop || (w_free >= CNT_W'(2)) ||
                      ((w_free == CNT_W'(1)) && !w_mem_slot);

    assign w_mem_push = MemValid && MemReady && !w_mem_drop;
    assign w_alu_push = AluValid && AluReady && !w_alu_drop;
    assign w_pop      = (r_count != '0);

    // The load is the older instruction, so it takes the first slot when both push.
    assign w_alu_idx   = w_mem_push ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
    assign w_push_cnt  = CNT_W'(w_mem_push) + CNT_W'(w_alu_push);
    assign w_count_nxt = r_count + w_push_cnt - CNT_W'(w_pop);

    always_comb begin
        w_entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count);
        end
    end

    always_comb begin
        w_pend_a = r_write_flag && (r_dir_w == QueryA);
        w_pend_b = r_write_flag && (r_dir_w == QueryB);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && (r_fifo_dir[i] == QueryA)) begin
                w_pend_a = 1'b1;
            end
            if (w_entry_valid[i] && (r_fifo_dir[i] == QueryB)) begin
                w_pend_b = 1'b1;
            end
        end
`ifdef REGBANK_WB_ZERO_REG_EN
        if (QueryA == '0) begin
            w_pend_a = 1'b0;
        end
        if (QueryB == '0) begin
            w_pend_b = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_write_flag <= 1'b0;
            r_dir_w      <= '0;
            r_write_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_dir[i]  <= '0;
                r_fifo_data[i] <= '0;
            end
        end else begin
            if (w_mem_push) begin
                r_fifo_dir[r_wr_ptr]  <= MemDir;
                r_fifo_data[r_wr_ptr] <= MemData;
            end
            if (w_alu_push) begin
                r_fifo_dir[w_alu_idx]  <= AluDir;
                r_fifo_data[w_alu_idx] <= AluData;
            end
            r_wr_ptr     <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_count      <= w_count_nxt;
            r_write_flag <= w_pop;
            // Address and data hold their last value on idle cycles.
            if (w_pop) begin
                r_dir_w      <= r_fifo_dir[r_rd_ptr];
                r_write_data <= r_fifo_data[r_rd_ptr];
                r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign PendingA  = w_pend_a;
    assign PendingB  = w_pend_b;
    assign WriteFlag = r_write_flag;
    assign DirW      = r_dir_w;
    assign WriteData = r_write_data;
    assign Count     = r_count;
    assign Full      = (r_count == CNT_W'(DEPTH));
    assign Empty     = (r_count == '0);

endmodule

// File: tb/tb_regbank_writeback.sv
// Directed bench for regbank_writeback (DEPTH=4): reset, ordering, backpressure, hazard query, register 0.
module tb_regbank_writeback;

    logic        clk;
    logic        rst_n;
    logic        AluValid, AluReady, MemValid, MemReady;
    logic [4:0]  AluDir, MemDir, QueryA, QueryB, DirW;
    logic [31:0] AluData, MemData, WriteData;
    logic        PendingA, PendingB, WriteFlag, Full, Empty;
    logic [2:0]  Count;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0]  dir;
        logic [31:0] data;
    } ent_t;

    regbank_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .AluValid(AluValid), .AluReady(AluReady), .AluDir(AluDir), .AluData(AluData),
        .MemValid(MemValid), .MemReady(MemReady), .MemDir(MemDir), .MemData(MemData),
        .QueryA(QueryA), .QueryB(QueryB), .PendingA(PendingA), .PendingB(PendingB),
        .WriteFlag(WriteFlag), .DirW(DirW), .WriteData(WriteData),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        AluValid = 1'b0;
        MemValid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); QueryA = 5'd31; QueryB = 5'd30;
        AluDir = '0; AluData = '0; MemDir = '0; MemData = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (Count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", Count); end
        n_cmp++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", Empty); end
        n_cmp++; if (Full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", Full); end
        n_cmp++; if ({WriteFlag, DirW, WriteData} !== 38'd0) begin
            n_fail++; $display("FAIL reset_outputs got wf=%b dir=%0d data=%h want 0", WriteFlag, DirW, WriteData);
        end
        // Three entries queued: 2 pushes, then 2 pushes minus 1 pop.
        MemValid = 1; MemDir = 1; MemData = 32'hA1; AluValid = 1; AluDir = 2; AluData = 32'hA2;
        step();
        MemDir = 4; MemData = 32'hA4; AluDir = 5; AluData = 32'hA5;
        step();
        idle();
        n_cmp++; if (Count !== 3'd3) begin n_fail++; $display("FAIL prefill_count got %0d want 3", Count); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (Count !== 3'd0) begin n_fail++; $display("FAIL async_reset_count got %0d want 0", Count); end
        n_cmp++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL async_reset_empty got %b want 1", Empty); end
        n_cmp++; if (WriteFlag !== 1'b0) begin n_fail++; $display("FAIL async_reset_wf got %b want 0", WriteFlag); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (WriteFlag !== 1'b0 || Count !== 3'd0) begin
                n_fail++; $display("FAIL stale_write cyc %0d got wf=%b cnt=%0d want 0/0", i, WriteFlag, Count);
            end
        end
    endtask

    task automatic test_single_alu();
        AluValid = 1; AluDir = 7; AluData = 32'hDEADBEEF;
        #1;
        n_cmp++; if (AluReady !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", AluReady); end
        step();
        idle();
        n_cmp++; if (Count !== 3'd1 || WriteFlag !== 1'b0) begin
            n_fail++; $display("FAIL single_k got cnt=%0d wf=%b want 1/0", Count, WriteFlag);
        end
        step();
        n_cmp++; if (WriteFlag !== 1'b1 || DirW !== 5'd7 || WriteData !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_write got wf=%b dir=%0d data=%h want 1/7/deadbeef", WriteFlag, DirW, WriteData);
        end
        step();
        n_cmp++; if (WriteFlag !== 1'b0 || Empty !== 1'b1) begin
            n_fail++; $display("FAIL single_after got wf=%b empty=%b want 0/1", WriteFlag, Empty);
        end
    endtask

    task automatic test_dual_push();
        QueryA = 3;
        MemValid = 1; MemDir = 3; MemData = 32'h11; AluValid = 1; AluDir = 3; AluData = 32'h22;
        #1;
        n_cmp++; if (MemReady !== 1'b1 || AluReady !== 1'b1) begin
            n_fail++; $display("FAIL dual_ready got mr=%b ar=%b want 1/1", MemReady, AluReady);
        end
        n_cmp++; if (PendingA !== 1'b0) begin n_fail++; $display("FAIL dual_pend_pre got %b want 0", PendingA); end
        step();
        idle();
        n_cmp++; if (Count !== 3'd2 || PendingA !== 1'b1) begin
            n_fail++; $display("FAIL dual_queued got cnt=%0d pa=%b want 2/1", Count, PendingA);
        end
        step();
        n_cmp++; if (WriteFlag !== 1'b1 || DirW !== 5'd3 || WriteData !== 32'h11 || PendingA !== 1'b1) begin
            n_fail++; $display("FAIL dual_first got wf=%b dir=%0d data=%h pa=%b want 1/3/11/1", WriteFlag, DirW, WriteData, PendingA);
        end
        step();
        n_cmp++; if (WriteFlag !== 1'b1 || WriteData !== 32'h22 || PendingA !== 1'b1 || Count !== 3'd0) begin
            n_fail++; $display("FAIL dual_second got wf=%b data=%h pa=%b cnt=%0d want 1/22/1/0", WriteFlag, WriteData, PendingA, Count);
        end
        step();
        n_cmp++; if (WriteFlag !== 1'b0 || PendingA !== 1'b0) begin
            n_fail++; $display("FAIL dual_done got wf=%b pa=%b want 0/0", WriteFlag, PendingA);
        end
    endtask

    task automatic test_hazard();
        QueryA = 9; QueryB = 10;
        AluValid = 1; AluDir = 9; AluData = 32'h99;
        step();
        idle();
        n_cmp++; if (PendingA !== 1'b1 || PendingB !== 1'b0) begin
            n_fail++; $display("FAIL hazard_queued got pa=%b pb=%b want 1/0", PendingA, PendingB);
        end
        step();
        n_cmp++; if (WriteFlag !== 1'b1 || DirW !== 5'd9 || PendingA !== 1'b1 || PendingB !== 1'b0) begin
            n_fail++; $display("FAIL hazard_out got wf=%b dir=%0d pa=%b pb=%b want 1/9/1/0", WriteFlag, DirW, PendingA, PendingB);
        end
        step();
        n_cmp++; if (PendingA !== 1'b0) begin n_fail++; $display("FAIL hazard_clear got %b want 0", PendingA); end
    endtask

    task automatic test_back_to_back();
        ent_t q[$];
        ent_t e;
        int   m_count;
        int   free;
        logic exp_mr, exp_ar, exp_wf;
        m_count = 0;
        QueryA = 31; QueryB = 30;
        for (int cyc = 0; cyc < 33; cyc++) begin
            if (cyc < 3) begin
                MemValid = 1; MemDir = 5'(cyc + 1); MemData = 32'h100 + cyc;
                AluValid = 1; AluDir = 5'(cyc + 11); AluData = 32'h200 + cyc;
            end else if (cyc < 23) begin
                MemValid = 1'($urandom_range(0, 1)); MemDir = 5'($urandom_range(1, 31)); MemData = $urandom;
                AluValid = 1'($urandom_range(0, 1)); AluDir = 5'($urandom_range(1, 31)); AluData = $urandom;
            end else begin
                idle();
            end
            #1;
            free = 4 - m_count;
            exp_mr = (free >= 1);
            exp_ar = (free >= 2) || (free == 1 && !MemValid);
            n_cmp++; if (MemReady !== exp_mr || AluReady !== exp_ar) begin
                n_fail++; $display("FAIL bp_ready cyc %0d got mr=%b ar=%b want %b/%b", cyc, MemReady, AluReady, exp_mr, exp_ar);
            end
            n_cmp++; if (Count !== 3'(m_count) || Full !== (m_count == 4) || Empty !== (m_count == 0)) begin
                n_fail++; $display("FAIL bp_count cyc %0d got cnt=%0d full=%b empty=%b want cnt=%0d", cyc, Count, Full, Empty, m_count);
            end
            if (cyc == 2) begin
                n_cmp++; if (MemReady !== 1'b1 || AluReady !== 1'b0 || Count !== 3'd3) begin
                    n_fail++; $display("FAIL bp_one_slot got mr=%b ar=%b cnt=%0d want 1/0/3", MemReady, AluReady, Count);
                end
            end
            exp_wf = (m_count > 0);
            e = '0;
            if (exp_wf) e = q.pop_front();
            if (MemValid && exp_mr) q.push_back({MemDir, MemData});
            if (AluValid && exp_ar) q.push_back({AluDir, AluData});
            m_count = q.size();
            step();
            n_cmp++; if (WriteFlag !== exp_wf || (exp_wf && (DirW !== e.dir || WriteData !== e.data))) begin
                n_fail++; $display("FAIL bp_write cyc %0d got wf=%b dir=%0d data=%h want wf=%b dir=%0d data=%h",
                                   cyc, WriteFlag, DirW, WriteData, exp_wf, e.dir, e.data);
            end
        end
        n_cmp++; if (Count !== 3'd0 || Empty !== 1'b1) begin
            n_fail++; $display("FAIL bp_drained got cnt=%0d empty=%b want 0/1", Count, Empty);
        end
    endtask

    task automatic test_zero_reg();
        step(); step();
        QueryA = 0;
        AluValid = 1; AluDir = 0; AluData = 32'h55;
        #1;
        n_cmp++; if (AluReady !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b want 1", AluReady); end
        step();
        idle();
`ifdef REGBANK_WB_ZERO_REG_EN
        n_cmp++; if (Count !== 3'd0 || PendingA !== 1'b0) begin
            n_fail++; $display("FAIL zero_dropped got cnt=%0d pa=%b want 0/0", Count, PendingA);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (WriteFlag !== 1'b0 || PendingA !== 1'b0) begin
                n_fail++; $display("FAIL zero_no_write cyc %0d got wf=%b pa=%b want 0/0", i, WriteFlag, PendingA);
            end
        end
`else
        n_cmp++; if (Count !== 3'd1 || PendingA !== 1'b1) begin
            n_fail++; $display("FAIL zero_queued got cnt=%0d pa=%b want 1/1", Count, PendingA);
        end
        step();
        n_cmp++; if (WriteFlag !== 1'b1 || DirW !== 5'd0 || WriteData !== 32'h55) begin
            n_fail++; $display("FAIL zero_write got wf=%b dir=%0d data=%h want 1/0/55", WriteFlag, DirW, WriteData);
        end
        step();
        n_cmp++; if (WriteFlag !== 1'b0) begin n_fail++; $display("FAIL zero_after got %b want 0", WriteFlag); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_dual_push();
        test_hazard();
        test_back_to_back();
        test_zero_reg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
